pipe_addsub_n: RTL and testbench

//  Parametrised, pipelined WIDTH-bit adder/subtractor with carry-in, carry-out and signed overflow.
//  The carry chain is split into STAGES equal slices, with one register stage per slice.
//  It accepts one operation per clock through a valid/ready handshake and supports output back-pressure.

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/pipe_addsub_n_if.sv | 28 ++
 rtl/addsub_slice.sv | 19 +
 rtl/pipe_addsub_n.sv | 117 +++++++++++
 tb/tb_pipe_addsub_n.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
`ifndef ADDSUB_PKG_SV
`define ADDSUB_PKG_SV

// True when WIDTH splits evenly into STAGES carry slices.
`define ADDSUB_LEGAL(W, S) (((W) % (S)) == 0)

package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of one carry slice.
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

`endif

// File: rtl/pipe_addsub_n_if.sv
// Operand/result handshake bundle for pipe_addsub_n.
interface pipe_addsub_n_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Arithmetic block side.
  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder; reports the carry out and the carry into the slice MSB.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Full slice sum with carry out.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};

  // Carry into the MSB recovered from the MSB sum bit.
  assign c_msb = a[SLICE-1] ^ b[SLICE-1] ^ s[SLICE-1];

endmodule

// File: rtl/pipe_addsub_n.sv
// Pipelined WIDTH-bit adder/subtractor: one carry slice per register stage,
// whole-pipe freeze on output back-pressure.
module pipe_addsub_n
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  pipe_addsub_n_if.slave bus
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!`ADDSUB_LEGAL(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_addsub_n: WIDTH must be a multiple of STAGES");
  end

  logic advance;

  // The pipe moves only when the output slot is empty or being consumed.
  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand-B bits not yet consumed when entering this stage.
    localparam int BW = WIDTH - k * SLICE;

    // rs_*: result bits below slice k, operand A bits from slice k upward.
    logic [WIDTH-1:0] rs_in;
    logic [WIDTH-1:0] rs_next;
    logic [BW-1:0]    bh_in;
    logic             c_in;
    logic             v_in;
    logic [SLICE-1:0] s_slc;
    logic             co_slc;
    logic             cm_slc;
    logic             vld_q;

    if (k == 0) begin : g_head
      // Subtraction becomes a + ~b + ~cin right at the entry.
      assign rs_in = bus.a;
      assign bh_in = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
      assign c_in  = (bus.op_sub == OP_SUB) ? ~bus.cin : bus.cin;
      assign v_in  = bus.in_valid;
    end else begin : g_body
      assign rs_in = g_stage[k-1].g_mid.rs_q;
      assign bh_in = g_stage[k-1].g_mid.bh_q;
      assign c_in  = g_stage[k-1].g_mid.c_q;
      assign v_in  = g_stage[k-1].vld_q;
    end

    addsub_slice #(.SLICE(SLICE)) u_slice (
      .a     (rs_in[k*SLICE +: SLICE]),
      .b     (bh_in[SLICE-1:0]),
      .ci    (c_in),
      .s     (s_slc),
      .co    (co_slc),
      .c_msb (cm_slc)
    );

    // Replace operand slice k with its freshly computed result slice.
    always_comb begin
      rs_next = rs_in;
      rs_next[k*SLICE +: SLICE] = s_slc;
    end

    // ---- stage k register boundary ----
    // Valid chain bit for this stage; cleared by reset so in-flight ops vanish.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0]    rs_q;
      logic [BW-SLICE-1:0] bh_q;
      logic                c_q;

      // Partial result, remaining operands and slice carry ride to the next stage.
      always_ff @(posedge clk) begin
        if (advance) begin
          rs_q <= rs_next;
          bh_q <= bh_in[BW-1:SLICE];
          c_q  <= co_slc;
        end
      end
    end else begin : g_tail
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             ovf_q;

      // Output register; signed overflow is the XOR of the two top carries.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (advance) begin
          sum_q  <= rs_next;
          cout_q <= co_slc;
          ovf_q  <= co_slc ^ cm_slc;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.sum       = g_stage[STAGES-1].g_tail.sum_q;
  assign bus.cout      = g_stage[STAGES-1].g_tail.cout_q;
  assign bus.ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipe_addsub_n.sv
// Directed and random checks of pipe_addsub_n (WIDTH=8, STAGES=2).
module tb_pipe_addsub_n;
  import addsub_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pipe_addsub_n_if #(.WIDTH(W)) bus ();

  pipe_addsub_n #(.WIDTH(W), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [9:0] sb_q [$];

  // Reference: {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] r;
    logic       ov;
    bb = sub ? ~b : b;
    cc = sub ? ~cin : cin;
    r  = {1'b0, a} + {1'b0, bb} + {8'b0, cc};
    ov = (a[7] == bb[7]) && (r[7] != a[7]);
    return {ov, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_op(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
  endtask

  // Single op with the consumer always ready; result must appear exactly 2 clk later.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
    @(posedge clk) #1 set_op(a, b, cin, sub);
    @(posedge clk) #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, bus.out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, bus.out_valid, 1'b1);
    check({tag, "_sum"},   bus.sum, es);
    check({tag, "_cout"},  bus.cout, ec);
    check({tag, "_ovf"},   bus.ovf, eo);
  endtask

  initial begin
    logic       acc;
    logic       prev_hold;
    logic [10:0] prev_out;
    logic [9:0] exp_r;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = OP_ADD;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum",       bus.sum, 8'h00);
    check("rst_cout",      bus.cout, 1'b0);
    check("rst_ovf",       bus.ovf, 1'b0);
    check("rst_in_ready",  bus.in_ready, 1'b1);
    @(posedge clk) #1;
    @(posedge clk) #1 rst_n = 1'b1;

    // Directed arithmetic
    run_op("add_ff_01",    8'hFF, 8'h01, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01",    8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1);
    run_op("sub_80_01",    8'h80, 8'h01, 1'b0, OP_SUB, 8'h7F, 1'b1, 1'b1);
    run_op("sub_05_07",    8'h05, 8'h07, 1'b0, OP_SUB, 8'hFE, 1'b0, 1'b0);
    run_op("sub_07_05_c1", 8'h07, 8'h05, 1'b1, OP_SUB, 8'h01, 1'b1, 1'b0);
    run_op("add_0f_01_c1", 8'h0F, 8'h01, 1'b1, OP_ADD, 8'h11, 1'b0, 1'b0);

    // Stream with back-pressure
    @(posedge clk) #1 bus.out_ready = 1'b0;
    set_op(8'h10, 8'h20, 1'b0, OP_ADD);
    @(posedge clk) #1 set_op(8'hF0, 8'h20, 1'b0, OP_ADD);
    @(posedge clk) #1 set_op(8'h50, 8'h60, 1'b0, OP_SUB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_out", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, 10'h030});
      @(posedge clk) #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1'b1);
    check("stream_r0", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, 10'h030});
    @(posedge clk) #1 set_op(8'h70, 8'h70, 1'b0, OP_ADD);
    @(negedge clk);
    check("stream_r1", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, 10'h110});
    @(posedge clk) #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("stream_r2", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, 10'h0F0});
    @(posedge clk) #1;
    @(negedge clk);
    check("stream_r3", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, {1'b1, 10'h2E0});
    @(posedge clk) #1;
    @(negedge clk);
    check("stream_empty", bus.out_valid, 1'b0);

    // Reset with two ops in flight
    @(posedge clk) #1 set_op(8'h11, 8'h22, 1'b0, OP_ADD);
    @(posedge clk) #1 set_op(8'h33, 8'h44, 1'b0, OP_ADD);
    @(posedge clk) #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 1'b0);
    check("async_rst_sum",   bus.sum, 8'h00);
    @(posedge clk) #1;
    @(posedge clk) #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale", bus.out_valid, 1'b0);
    end
    run_op("post_rst", 8'h12, 8'h34, 1'b0, OP_ADD, 8'h46, 1'b0, 1'b0);

    // Random traffic against the reference model
    acc       = 1'b0;
    prev_hold = 1'b0;
    prev_out  = '0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk) #1;
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.cin      = 1'($urandom);
        bus.op_sub   = 1'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_hold)
        check("rnd_hold", {bus.out_valid, bus.ovf, bus.cout, bus.sum}, prev_out);
      acc = bus.in_valid && bus.in_ready;
      if (acc) sb_q.push_back(model(bus.a, bus.b, bus.cin, bus.op_sub));
      if (bus.out_valid && bus.out_ready) begin
        check("rnd_have_expected", (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
          exp_r = sb_q.pop_front();
          check("rnd_result", {bus.ovf, bus.cout, bus.sum}, exp_r);
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_out  = {bus.out_valid, bus.ovf, bus.cout, bus.sum};
    end

    // Drain
    @(posedge clk) #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        exp_r = sb_q.pop_front();
        check("drain_result", {bus.ovf, bus.cout, bus.sum}, exp_r);
      end
      @(posedge clk) #1;
    end
    check("drain_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
